// File: rtl/mips_debug_pkg.sv
// Shared command/ack byte codes and loader state encoding for the MIPS debug front end.
// The LD_CSUM state only exists when DEBUG_LOADER_CHECKSUM_EN is defined.
package mips_debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;

    localparam logic [7:0] ACK_OK   = 8'h4B;
    localparam logic [7:0] ACK_HALT = 8'h48;
    localparam logic [7:0] ACK_ERR  = 8'hEE;

    typedef enum logic [3:0] {
        IDLE,
        LD_CNT0,
        LD_CNT1,
        LD_DATA,
`ifdef DEBUG_LOADER_CHECKSUM_EN
        LD_CSUM,
`endif
        LD_WR,
        RUN,
        STEP_EN,
        STEP_WAIT,
        DUMP_RD,
        DUMP_TX,
        PC_TX,
        ACK_TX
    } state_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// Emits the low i_nbytes bytes of a word, least significant first, on a valid/ready channel.
// A one-cycle o_done pulse follows acceptance of the final byte.
module debug_tx_serializer #(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8,
    parameter int NB_CNT  = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_WORD-1:0] i_word,
    input  logic [NB_CNT-1:0]  i_nbytes,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_done
);

    logic [NB_WORD-1:0] shift;
    logic [NB_CNT-1:0]  remaining;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift      <= '0;
            remaining  <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (o_tx_valid) begin
                if (i_tx_ready) begin
                    if (remaining == NB_CNT'(1)) begin
                        o_tx_valid <= 1'b0;
                        o_done     <= 1'b1;
                    end else begin
                        shift     <= shift >> NB_BYTE;
                        o_tx_data <= NB_BYTE'(shift >> NB_BYTE);
                        remaining <= remaining - NB_CNT'(1);
                    end
                end
            end else if (i_load && (i_nbytes != '0)) begin
                shift      <= i_word;
                o_tx_data  <= NB_BYTE'(i_word);
                remaining  <= i_nbytes;
                o_tx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_debug_loader.sv
// Byte-stream debug loader: parses L/R/S/D host commands, loads imem, controls execution, dumps state.
// Define DEBUG_LOADER_CHECKSUM_EN to require an XOR checksum byte after each LOAD payload.
module mips_debug_loader #(
    parameter int NB_INST    = 32,
    parameter int NB_ADDR    = 32,
    parameter int NB_BYTE    = 8,
    parameter int NB_REG     = 5,
    parameter int N_REGS     = 32,
    parameter int IMEM_DEPTH = 256
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_imem_write,
    output logic [NB_ADDR-1:0] o_imem_address,
    output logic [NB_INST-1:0] o_imem_instruction,
    output logic               o_cpu_enable,
    output logic [NB_REG-1:0]  o_reg_address,
    input  logic [NB_INST-1:0] i_reg_data,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic               i_halt
);

    import mips_debug_pkg::*;

    localparam int BPW      = NB_INST / NB_BYTE;
    localparam int PC_BYTES = NB_ADDR / NB_BYTE;
    localparam int NB_WORD  = (NB_INST > NB_ADDR) ? NB_INST : NB_ADDR;
    localparam int NB_CNT   = $clog2(NB_WORD / NB_BYTE + 1);
    localparam int NB_BIDX  = (BPW > 1) ? $clog2(BPW) : 1;

    state_t                     state;
    logic [15:0]                word_cnt;
    logic [15:0]                word_idx;
    logic [NB_BIDX-1:0]         byte_idx;
    logic [NB_INST-NB_BYTE-1:0] word_buf;
    logic                       overflow;
    logic [7:0]                 ack_code;
    logic                       phase;
    logic                       ser_load;
    logic [NB_WORD-1:0]         ser_word;
    logic [NB_CNT-1:0]          ser_nbytes;
    logic                       ser_done;
    logic                       rx_fire;
`ifdef DEBUG_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0]         csum;
`endif

    assign rx_fire = i_rx_valid && o_rx_ready;

    // phase marks the second cycle of DUMP_RD (read data valid) and the issued ack in ACK_TX.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state              <= IDLE;
            o_rx_ready         <= 1'b0;
            o_imem_write       <= 1'b0;
            o_imem_address     <= '0;
            o_imem_instruction <= '0;
            o_cpu_enable       <= 1'b0;
            o_reg_address      <= '0;
            word_cnt           <= '0;
            word_idx           <= '0;
            byte_idx           <= '0;
            word_buf           <= '0;
            overflow           <= 1'b0;
            ack_code           <= '0;
            phase              <= 1'b0;
            ser_load           <= 1'b0;
            ser_word           <= '0;
            ser_nbytes         <= '0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
            csum               <= '0;
`endif
        end else begin
            o_imem_write <= 1'b0;
            ser_load     <= 1'b0;
            case (state)
                IDLE: begin
                    o_rx_ready <= 1'b1;
                    if (rx_fire) begin
                        if (i_rx_data == NB_BYTE'(CMD_LOAD)) begin
                            state <= LD_CNT0;
                        end else begin
                            o_rx_ready <= 1'b0;
                            phase      <= 1'b0;
                            if (i_rx_data == NB_BYTE'(CMD_RUN)) begin
                                o_cpu_enable <= 1'b1;
                                state        <= RUN;
                            end else if (i_rx_data == NB_BYTE'(CMD_STEP)) begin
                                o_cpu_enable <= 1'b1;
                                state        <= STEP_EN;
                            end else if (i_rx_data == NB_BYTE'(CMD_DUMP)) begin
                                o_reg_address <= '0;
                                state         <= DUMP_RD;
                            end else begin
                                ack_code <= ACK_ERR;
                                state    <= ACK_TX;
                            end
                        end
                    end
                end
                LD_CNT0: if (rx_fire) begin
                    word_cnt[7:0] <= 8'(i_rx_data);
                    state         <= LD_CNT1;
                end
                LD_CNT1: if (rx_fire) begin
                    word_cnt[15:8] <= 8'(i_rx_data);
                    word_idx       <= '0;
                    byte_idx       <= '0;
                    overflow       <= 1'b0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
                    csum           <= '0;
`endif
                    if ({8'(i_rx_data), word_cnt[7:0]} == 16'd0) begin
                        o_rx_ready <= 1'b0;
                        phase      <= 1'b0;
                        ack_code   <= ACK_OK;
                        state      <= ACK_TX;
                    end else begin
                        state <= LD_DATA;
                    end
                end
                LD_DATA: if (rx_fire) begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
                    csum <= csum ^ i_rx_data;
`endif
                    if (byte_idx == NB_BIDX'(BPW - 1)) begin
                        byte_idx           <= '0;
                        o_rx_ready         <= 1'b0;
                        state              <= LD_WR;
                        o_imem_address     <= NB_ADDR'(word_idx);
                        o_imem_instruction <= {i_rx_data, word_buf};
                        // Words past the end of imem still drain the stream but are not written.
                        if ({16'd0, word_idx} < 32'(IMEM_DEPTH))
                            o_imem_write <= 1'b1;
                        else
                            overflow <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + NB_BIDX'(1);
                        word_buf <= {i_rx_data, word_buf[NB_INST-NB_BYTE-1:NB_BYTE]};
                    end
                end
                LD_WR: begin
                    if (word_idx == word_cnt - 16'd1) begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
                        o_rx_ready <= 1'b1;
                        state      <= LD_CSUM;
`else
                        phase    <= 1'b0;
                        ack_code <= overflow ? ACK_ERR : ACK_OK;
                        state    <= ACK_TX;
`endif
                    end else begin
                        word_idx   <= word_idx + 16'd1;
                        o_rx_ready <= 1'b1;
                        state      <= LD_DATA;
                    end
                end
`ifdef DEBUG_LOADER_CHECKSUM_EN
                LD_CSUM: if (rx_fire) begin
                    o_rx_ready <= 1'b0;
                    phase      <= 1'b0;
                    ack_code   <= (overflow || (i_rx_data != csum)) ? ACK_ERR : ACK_OK;
                    state      <= ACK_TX;
                end
`endif
                RUN: if (i_halt) begin
                    o_cpu_enable <= 1'b0;
                    phase        <= 1'b0;
                    ack_code     <= ACK_HALT;
                    state        <= ACK_TX;
                end
                STEP_EN: begin
                    o_cpu_enable <= 1'b0;
                    state        <= STEP_WAIT;
                end
                STEP_WAIT: begin
                    ser_word   <= NB_WORD'(i_pc);
                    ser_nbytes <= NB_CNT'(PC_BYTES);
                    ser_load   <= 1'b1;
                    state      <= PC_TX;
                end
                DUMP_RD: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase      <= 1'b0;
                        ser_word   <= NB_WORD'(i_reg_data);
                        ser_nbytes <= NB_CNT'(BPW);
                        ser_load   <= 1'b1;
                        state      <= DUMP_TX;
                    end
                end
                DUMP_TX: if (ser_done) begin
                    if (o_reg_address == NB_REG'(N_REGS - 1)) begin
                        ser_word   <= NB_WORD'(i_pc);
                        ser_nbytes <= NB_CNT'(PC_BYTES);
                        ser_load   <= 1'b1;
                        state      <= PC_TX;
                    end else begin
                        o_reg_address <= o_reg_address + NB_REG'(1);
                        state         <= DUMP_RD;
                    end
                end
                PC_TX: if (ser_done) begin
                    o_rx_ready <= 1'b1;
                    state      <= IDLE;
                end
                ACK_TX: begin
                    if (!phase) begin
                        phase      <= 1'b1;
                        ser_word   <= NB_WORD'(ack_code);
                        ser_nbytes <= NB_CNT'(1);
                        ser_load   <= 1'b1;
                    end else if (ser_done) begin
                        phase      <= 1'b0;
                        o_rx_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    debug_tx_serializer #(
        .NB_WORD (NB_WORD),
        .NB_BYTE (NB_BYTE),
        .NB_CNT  (NB_CNT)
    ) u_tx_serializer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (ser_load),
        .i_word     (ser_word),
        .i_nbytes   (ser_nbytes),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_done     (ser_done)
    );

endmodule

// File: tb/tb_mips_debug_loader.sv
// Directed scoreboard bench for mips_debug_loader built with a 2-word imem to reach the depth limit.
`timescale 1ns/1ps
module tb_mips_debug_loader;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic [31:0] reg_data = 32'h0;
    logic [31:0] pc = 32'h4;
    logic        halt = 1'b0;
    logic        toggle_ready = 1'b0;

    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_imem_write;
    logic [31:0] o_imem_address;
    logic [31:0] o_imem_instruction;
    logic        o_cpu_enable;
    logic [4:0]  o_reg_address;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;
    int en_count = 0;
    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];
    logic        stalled = 1'b0;
    logic [7:0]  held = 8'h00;

    mips_debug_loader #(
        .NB_INST(32), .NB_ADDR(32), .NB_BYTE(8), .NB_REG(5), .N_REGS(32), .IMEM_DEPTH(DEPTH)
    ) dut (
        .i_clk              (clk),
        .i_reset            (rst_n),
        .i_rx_data          (rx_data),
        .i_rx_valid         (rx_valid),
        .o_rx_ready         (o_rx_ready),
        .o_tx_data          (o_tx_data),
        .o_tx_valid         (o_tx_valid),
        .i_tx_ready         (tx_ready),
        .o_imem_write       (o_imem_write),
        .o_imem_address     (o_imem_address),
        .o_imem_instruction (o_imem_instruction),
        .o_cpu_enable       (o_cpu_enable),
        .o_reg_address      (o_reg_address),
        .i_reg_data         (reg_data),
        .i_pc               (pc),
        .i_halt             (halt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reportExtra(input string tag);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s observed=unexpected-event expected=none", tag);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!o_rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rx_timeout observed=ready-low expected=ready-high");
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic sendLoad(input int n, input logic [31:0] base);
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        for (int i = 0; i < n; i++)
            if (i < DEPTH) exp_wr.push_back({32'(i), base + 32'(i)});
        exp_tx.push_back((n > DEPTH) ? 8'hEE : 8'h4B);
        applyStimulus(8'h4C);
        applyStimulus(n[7:0]);
        applyStimulus(n[15:8]);
        for (int i = 0; i < n; i++) begin
            w = base + 32'(i);
            for (int b = 0; b < 4; b++) begin
                applyStimulus(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
`ifdef DEBUG_LOADER_CHECKSUM_EN
        if (n != 0) applyStimulus(x);
`endif
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checkOutput({tag, "_pending"}, 64'(exp_tx.size() + exp_wr.size()), 64'd0);
        checkOutput({tag, "_rx_ready_back"}, 64'(o_rx_ready), 64'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctrl"},
                    64'({o_rx_ready, o_tx_valid, o_tx_data, o_imem_write, o_cpu_enable, o_reg_address}), 64'd0);
        checkOutput({tag, "_imem"}, {o_imem_address, o_imem_instruction}, 64'd0);
    endtask

    // Register file model: one-cycle read latency from o_reg_address.
    initial begin
        logic [4:0] a;
        forever begin
            @(negedge clk);
            a = o_reg_address;
            @(posedge clk);
            #1 reg_data = 32'(a) + 32'h100;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2 tx_ready = toggle_ready ? ~tx_ready : 1'b1;
        end
    end

    // Scoreboard monitor: every accepted tx byte and every write pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) checkOutput("tx_hold", 64'({o_tx_valid, o_tx_data}), 64'({1'b1, held}));
            if (o_tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) reportExtra("tx_extra_byte");
                else checkOutput("tx_byte", 64'(o_tx_data), 64'(exp_tx.pop_front()));
            end
            stalled = o_tx_valid && !tx_ready;
            held    = o_tx_data;
            if (o_imem_write) begin
                wr_count++;
                if (exp_wr.size() == 0) reportExtra("imem_extra_write");
                else checkOutput("imem_write", {o_imem_address, o_imem_instruction}, exp_wr.pop_front());
            end
            if (o_cpu_enable) en_count++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wr_before;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rx_ready_after_reset", 64'(o_rx_ready), 64'd1);

        $display("[TB] load one word");
        sendLoad(1, 32'h00231020);
        waitDrain("load1", 200);
        checkOutput("load1_writes", 64'(wr_count), 64'd1);

        $display("[TB] load zero words");
        sendLoad(0, 32'h0);
        waitDrain("load0", 200);

        $display("[TB] depth overflow");
        wr_before = wr_count;
        sendLoad(3, 32'hA0B0C0D0);
        waitDrain("overflow", 200);
        checkOutput("overflow_writes", 64'(wr_count - wr_before), 64'd2);

        $display("[TB] unknown command");
        exp_tx.push_back(8'hEE);
        applyStimulus(8'h00);
        waitDrain("badcmd", 200);

        $display("[TB] run");
        en_count = 0;
        exp_tx.push_back(8'h48);
        applyStimulus(8'h52);
        checkOutput("run_enable_rise", 64'(o_cpu_enable), 64'd1);
        checkOutput("run_rx_ready_low", 64'(o_rx_ready), 64'd0);
        repeat (5) @(posedge clk);
        #1 halt = 1'b1;
        waitDrain("run", 200);
        halt = 1'b0;
        checkOutput("run_enable_cycles", 64'(en_count), 64'd6);

        $display("[TB] run with halt already high");
        en_count = 0;
        halt = 1'b1;
        exp_tx.push_back(8'h48);
        applyStimulus(8'h52);
        waitDrain("run_halted", 200);
        halt = 1'b0;
        checkOutput("run_halted_enable_cycles", 64'(en_count), 64'd1);

        $display("[TB] step");
        en_count = 0;
        pc = 32'h4;
        exp_tx.push_back(8'h04); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        applyStimulus(8'h53);
        waitDrain("step", 200);
        checkOutput("step_enable_cycles", 64'(en_count), 64'd1);

        $display("[TB] reset mid-load");
        wr_before = wr_count;
        applyStimulus(8'h4C);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        @(negedge clk);
        rst_n = 1'b0;
        #1 checkResetOutputs("midload_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midload_no_write", 64'(wr_count - wr_before), 64'd0);

        $display("[TB] dump with throttled tx_ready");
        toggle_ready = 1'b1;
        for (int r = 0; r < 32; r++) begin
            logic [31:0] w;
            w = 32'(r) + 32'h100;
            for (int b = 0; b < 4; b++) exp_tx.push_back(w[8*b +: 8]);
        end
        for (int b = 0; b < 4; b++) exp_tx.push_back(pc[8*b +: 8]);
        applyStimulus(8'h44);
        waitDrain("dump", 3000);
        toggle_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
